// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bundle: instruction-memory handshake, redirect/halt controls and the
// decode-side head-of-queue view. master = fetch queue, slave = memory/decode side.
interface instr_fetch_queue_if #(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [DW-1:0] imem_rdata;

  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          halt;
  logic          deq_en;

  logic          out_valid;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic [CW-1:0] count;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc, count,
    input  imem_ack, imem_rdata, redirect, redirect_pc, halt, deq_en
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc, count,
    output imem_ack, imem_rdata, redirect, redirect_pc, halt, deq_en
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Sequential instruction fetch with a DEPTH-entry {pc, instr} queue and redirect flush.
// Define FQ_BYPASS_EN to forward an ack'd word straight to the head when the queue is empty.
module instr_fetch_queue #(
  parameter int            AW       = 16,
  parameter int            DW       = 16,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_fetch_queue_if.master  bus
);
  localparam int            PW   = $clog2(DEPTH);
  localparam int            CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t        state, state_next;
  logic [AW-1:0] req_addr, req_addr_next;
  logic [AW-1:0] pend_pc, pend_pc_next;

  logic [AW-1:0] pc_mem    [DEPTH];
  logic [DW-1:0] instr_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;

  logic ack_in_req;
  logic stored_valid;
  logic bypass;
  logic push;
  logic pop;

  // A response only counts when it answers a live REQ and no redirect kills it.
  assign ack_in_req   = (state == REQ) && bus.imem_ack && !bus.redirect;
  assign stored_valid = (count != '0);

`ifdef FQ_BYPASS_EN
  assign bypass = !stored_valid && ack_in_req;
`else
  assign bypass = 1'b0;
`endif

  assign pop        = stored_valid && bus.deq_en && !bus.redirect;
  assign push       = ack_in_req && !(bypass && bus.deq_en);
  assign count_next = count + CW'(push) - CW'(pop);

  // NOTE: always_comb assigns every output a default first so no path can infer a latch.
  always_comb begin
    state_next    = state;
    req_addr_next = req_addr;
    pend_pc_next  = pend_pc;
    unique case (state)
      IDLE: begin
        if (bus.redirect) begin
          req_addr_next = bus.redirect_pc;
          state_next    = bus.halt ? IDLE : REQ;
        end else if (!bus.halt && (count < FULL)) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (bus.redirect) begin
          if (bus.imem_ack) begin
            req_addr_next = bus.redirect_pc;
            state_next    = bus.halt ? IDLE : REQ;
          end else begin
            pend_pc_next = bus.redirect_pc;
            state_next   = DISCARD;
          end
        end else if (bus.imem_ack) begin
          req_addr_next = req_addr + AW'(1);
          state_next    = (!bus.halt && (count_next < FULL)) ? REQ : IDLE;
        end
      end
      DISCARD: begin
        // The stale response is dropped; a redirect landing on the same edge wins.
        if (bus.imem_ack) begin
          req_addr_next = bus.redirect ? bus.redirect_pc : pend_pc;
          state_next    = bus.halt ? IDLE : REQ;
        end else if (bus.redirect) begin
          pend_pc_next = bus.redirect_pc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      req_addr <= RESET_PC;
      pend_pc  <= RESET_PC;
    end else begin
      state    <= state_next;
      req_addr <= req_addr_next;
      pend_pc  <= pend_pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
    end
  end

  // NOTE: storage is not reset; head outputs are gated by count, so stale entries never leak.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_mem[wr_ptr]    <= req_addr;
      instr_mem[wr_ptr] <= bus.imem_rdata;
    end
  end

  always_comb begin
    bus.out_valid = stored_valid || bypass;
    bus.out_pc    = '0;
    bus.out_instr = '0;
    if (stored_valid) begin
      bus.out_pc    = pc_mem[rd_ptr];
      bus.out_instr = instr_mem[rd_ptr];
    end else if (bypass) begin
      bus.out_pc    = req_addr;
      bus.out_instr = bus.imem_rdata;
    end
  end

  assign bus.imem_req  = (state != IDLE);
  assign bus.imem_addr = req_addr;
  assign bus.count     = count;

  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (rst) push |-> (count != FULL)
  );

  a_addr_stable: assert property (
    @(posedge clk) disable iff (rst)
      (bus.imem_req && !bus.imem_ack) |=> (bus.imem_addr == $past(bus.imem_addr))
  );
endmodule
